// File: rtl/hs_npu_feeder.sv
// -----------------------------------------------------------------------------
// hs_npu_feeder
//
// Purpose
//   Feeds a ROWS x COLS weight-stationary systolic array. A job optionally
//   loads ROWS weight rows into the array by broadcasting each accepted row
//   on mac_b with a one-cycle mac_enable strobe. It then streams activation
//   vectors into the left column through a per-row skew chain, so that row r
//   sees a vector r cycles after row 0. The first weight row loaded is the
//   one that ends up in the bottom array row. A final drain phase flushes
//   the skew chains with zeros before done is pulsed.
//
// Parameters
//   ROWS  systolic array rows (a inputs, weight beats per load)
//   COLS  systolic array columns (b inputs)
//
// Ports
//   clk               single clock, rising edge
//   rst_n             asynchronous, active-low reset
//   start             one-cycle job request, only honoured in IDLE
//   cfg_load_weights  sampled with start: 1 = reload weights first
//   weight_valid/_ready, weight_data [COLS][16]   weight-row handshake
//   act_valid/_ready, act_data [ROWS][16], act_last  activation handshake
//   mac_enable        weight-enable broadcast to every MAC
//   mac_b [COLS][16]  top-row MAC b inputs
//   mac_a [ROWS][16]  left-column MAC a inputs (skewed)
//   mac_a_valid[ROWS] valid tag travelling with mac_a
//   busy              state != IDLE
//   done              one-cycle pulse in the first IDLE cycle after a job
//
// Optional feature
//   HS_NPU_FEEDER_PERF_EN  when defined, adds perf_beats (accepted activation
//   vectors) and perf_stalls (STREAM cycles with act_valid low). Both are
//   32-bit, saturating, cleared by reset and by an accepted start.
// -----------------------------------------------------------------------------
module hs_npu_feeder #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      cfg_load_weights,
  input  logic                      weight_valid,
  output logic                      weight_ready,
  input  logic [COLS-1:0][15:0]     weight_data,
  input  logic                      act_valid,
  output logic                      act_ready,
  input  logic [ROWS-1:0][15:0]     act_data,
  input  logic                      act_last,
  output logic                      mac_enable,
  output logic [COLS-1:0][15:0]     mac_b,
  output logic [ROWS-1:0][15:0]     mac_a,
  output logic [ROWS-1:0]           mac_a_valid,
  output logic                      busy,
  output logic                      done
`ifdef HS_NPU_FEEDER_PERF_EN
  ,
  output logic [31:0]               perf_beats,
  output logic [31:0]               perf_stalls
`endif
);

  // Beat and drain counters both run 0..ROWS-1. Keep at least one bit so a
  // single-row array still has a legal counter type.
  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             loaded_q, loaded_d;
  logic             done_q, done_d;

  logic             mac_enable_q;
  logic [COLS-1:0][15:0] mac_b_q;

  logic             weight_fire;
  logic             act_fire;

  // Readies depend only on the registered state, so there is never a
  // combinational path from a valid to a ready.
  assign weight_ready = (state_q == S_LOAD);
  assign act_ready    = (state_q == S_STREAM);
  assign weight_fire  = weight_valid & weight_ready;
  assign act_fire     = act_valid & act_ready;

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign mac_enable   = mac_enable_q;
  assign mac_b        = mac_b_q;

  // ---------------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      loaded_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      loaded_q    <= loaded_d;
      done_q      <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    loaded_d    = loaded_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          beat_cnt_d  = '0;
          drain_cnt_d = '0;
          // Without a valid weight set, a reload is forced even if the
          // job asked to reuse the previous weights.
          if (cfg_load_weights || !loaded_q) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_STREAM;
          end
        end
      end

      S_LOAD: begin
        if (weight_fire) begin
          if (beat_cnt_q == LAST_IDX) begin
            beat_cnt_d = '0;
            loaded_d   = 1'b1;
            state_d    = S_STREAM;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end

      S_STREAM: begin
        if (act_fire && act_last) begin
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // ROWS cycles of zero injection push the last vector out of the
        // deepest skew stage; done then appears with the return to IDLE.
        if (drain_cnt_q == LAST_IDX) begin
          drain_cnt_d = '0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Weight broadcast: one mac_enable strobe per accepted row; mac_b keeps
  // the last row so the b bus does not toggle between beats.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_enable_q <= 1'b0;
      mac_b_q      <= '0;
    end else begin
      mac_enable_q <= weight_fire;
      if (weight_fire) begin
        mac_b_q <= weight_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Activation skew chains. Row gi has gi+1 stages. Every chain shifts every
  // cycle regardless of state; an idle cycle injects a zero/invalid bubble
  // so later vectors stay aligned diagonally across the array.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      logic [gi:0][15:0] data_q;
      logic [gi:0]       valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q  <= '0;
          valid_q <= '0;
        end else begin
          data_q[0]  <= act_fire ? act_data[gi] : 16'd0;
          valid_q[0] <= act_fire;
          for (int k = 1; k <= gi; k++) begin
            data_q[k]  <= data_q[k-1];
            valid_q[k] <= valid_q[k-1];
          end
        end
      end

      assign mac_a[gi]       = data_q[gi];
      assign mac_a_valid[gi] = valid_q[gi];
    end
  endgenerate

`ifdef HS_NPU_FEEDER_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters, saturating at all-ones. Only a start that is
  // actually honoured (IDLE) clears them.
  // ---------------------------------------------------------------------------
  logic [31:0] perf_beats_q;
  logic [31:0] perf_stalls_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_beats_q  <= '0;
      perf_stalls_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      perf_beats_q  <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (act_fire && (perf_beats_q != 32'hFFFF_FFFF)) begin
        perf_beats_q <= perf_beats_q + 32'd1;
      end
      if ((state_q == S_STREAM) && !act_valid &&
          (perf_stalls_q != 32'hFFFF_FFFF)) begin
        perf_stalls_q <= perf_stalls_q + 32'd1;
      end
    end
  end

  assign perf_beats  = perf_beats_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule
